// File: rtl/sonic_vc_pkg.sv
`default_nettype none
// ============================================================================
// sonic_vc_pkg : shared constants, beat layout and width helper for the VC FIFO
// Revision     : 1.0
// ============================================================================
package sonic_vc_pkg;

    localparam int CUT_THROUGH = 0;
    localparam int STORE_FWD   = 1;

    // Beat layout of the reference 128-bit datapath; the FIFO builds the same
    // layout from its own DATA_W/EMPTY_W localparams.
    localparam int BEAT_DATA_W  = 128;
    localparam int BEAT_EMPTY_W = 4;

    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [BEAT_EMPTY_W-1:0] empty;
        logic [BEAT_DATA_W-1:0]  data;
    } beat_t;

    // ceil(log2(value)), never below 1 so it is always a legal field width
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonic_vc_fifo_mem.sv
`default_nettype none
// ============================================================================
// sonic_vc_fifo_mem : simple dual-port RAM, synchronous write, async read
// Revision          : 1.0
// ============================================================================
module sonic_vc_fifo_mem #(
    parameter int WIDTH  = 134,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = sonic_vc_pkg::clog2w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sonic_vc_pkt_fifo.sv
`default_nettype none
// ============================================================================
// sonic_vc_pkt_fifo : single-clock Avalon-ST packet FIFO, show-ahead source,
//                     optional store-and-forward with oversize-packet escape
// Revision          : 1.0
// ============================================================================
module sonic_vc_pkt_fifo #(
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = sonic_vc_pkg::clog2w(DATA_W / 8),
    parameter int DEPTH     = 128,
    parameter int STORE_FWD = 0,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic                                  wrclock,
    input  logic                                  reset,
    input  logic [DATA_W-1:0]                     avalonst_sink_data,
    input  logic [EMPTY_W-1:0]                    avalonst_sink_empty,
    input  logic                                  avalonst_sink_startofpacket,
    input  logic                                  avalonst_sink_endofpacket,
    input  logic                                  avalonst_sink_valid,
    output logic                                  avalonst_sink_ready,
    output logic [DATA_W-1:0]                     avalonst_source_data,
    output logic [EMPTY_W-1:0]                    avalonst_source_empty,
    output logic                                  avalonst_source_startofpacket,
    output logic                                  avalonst_source_endofpacket,
    output logic                                  avalonst_source_valid,
    input  logic                                  avalonst_source_ready,
    output logic [sonic_vc_pkg::clog2w(DEPTH):0]  level,
    output logic                                  almost_full,
    output logic [sonic_vc_pkg::clog2w(DEPTH):0]  pkt_count
);

    import sonic_vc_pkg::*;

    localparam int                PTR_W    = clog2w(DEPTH);
    localparam int                LVL_W    = PTR_W + 1;
    localparam int                BEAT_W   = DATA_W + EMPTY_W + 2;
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  AF_LVL   = LVL_W'(AF_THRESH);
    localparam bit                SF_MODE  = (STORE_FWD != CUT_THROUGH);

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } pkt_beat_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             forced_q, forced_d;

    pkt_beat_t        w_wr_beat;
    pkt_beat_t        w_rd_beat;
    logic [BEAT_W-1:0] w_rd_word;
    logic             w_head_ok;
    logic             w_push;
    logic             w_pop;

    assign w_wr_beat = '{sop:   avalonst_sink_startofpacket,
                         eop:   avalonst_sink_endofpacket,
                         empty: avalonst_sink_empty,
                         data:  avalonst_sink_data};
    assign w_rd_beat = pkt_beat_t'(w_rd_word);

    sonic_vc_fifo_mem #(
        .WIDTH  (BEAT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk_i   (wrclock),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_wr_beat),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_rd_word)
    );

    assign avalonst_sink_ready   = (level_q != FULL_LVL) && !reset;
    assign avalonst_source_valid = (level_q != '0) && w_head_ok && !reset;
    assign w_push = avalonst_sink_valid && avalonst_sink_ready;
    assign w_pop  = avalonst_source_valid && avalonst_source_ready;

    assign avalonst_source_data          = w_rd_beat.data;
    assign avalonst_source_empty         = w_rd_beat.empty;
    assign avalonst_source_startofpacket = w_rd_beat.sop;
    assign avalonst_source_endofpacket   = w_rd_beat.eop;

    assign level       = level_q;
    assign pkt_count   = pkt_cnt_q;
    assign almost_full = (level_q >= AF_LVL) && !reset;

    generate
        if (SF_MODE) begin : g_store_fwd
            // A packet larger than the FIFO can never complete; release it
            // as cut-through until its eop leaves, otherwise we deadlock.
            always_comb begin
                forced_d = forced_q;
                if (w_pop && w_rd_beat.eop) begin
                    forced_d = 1'b0;
                end else if ((level_q == FULL_LVL) && (pkt_cnt_q == '0)) begin
                    forced_d = 1'b1;
                end
            end
            assign w_head_ok = (pkt_cnt_q != '0) || forced_q;
        end else begin : g_cut_through
            assign forced_d  = 1'b0;
            assign w_head_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(w_push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(w_pop);
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        case ({w_push && avalonst_sink_endofpacket, w_pop && w_rd_beat.eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge wrclock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
            forced_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
            forced_q  <= forced_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sonic_vc_pkt_fifo.sv
`default_nettype none
// ============================================================================
// tb_sonic_vc_pkt_fifo : directed bench for cut-through and store-and-forward
// Revision             : 1.0
// ============================================================================
module tb_sonic_vc_pkt_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [127:0] ct_sdata, ct_qdata, sf_sdata, sf_qdata;
    logic [3:0]   ct_sempty, ct_qempty, sf_sempty, sf_qempty;
    logic         ct_ssop, ct_seop, ct_svalid, ct_sready;
    logic         ct_qsop, ct_qeop, ct_qvalid, ct_qready;
    logic         sf_ssop, sf_seop, sf_svalid, sf_sready;
    logic         sf_qsop, sf_qeop, sf_qvalid, sf_qready;
    logic [3:0]   ct_level, ct_pkt, sf_level, sf_pkt;
    logic         ct_af, sf_af;

    sonic_vc_pkt_fifo #(
        .DATA_W(128), .DEPTH(8), .STORE_FWD(0), .AF_THRESH(4)
    ) u_ct (
        .wrclock(clk), .reset(rst),
        .avalonst_sink_data(ct_sdata), .avalonst_sink_empty(ct_sempty),
        .avalonst_sink_startofpacket(ct_ssop), .avalonst_sink_endofpacket(ct_seop),
        .avalonst_sink_valid(ct_svalid), .avalonst_sink_ready(ct_sready),
        .avalonst_source_data(ct_qdata), .avalonst_source_empty(ct_qempty),
        .avalonst_source_startofpacket(ct_qsop), .avalonst_source_endofpacket(ct_qeop),
        .avalonst_source_valid(ct_qvalid), .avalonst_source_ready(ct_qready),
        .level(ct_level), .almost_full(ct_af), .pkt_count(ct_pkt)
    );

    sonic_vc_pkt_fifo #(
        .DATA_W(128), .DEPTH(8), .STORE_FWD(1), .AF_THRESH(4)
    ) u_sf (
        .wrclock(clk), .reset(rst),
        .avalonst_sink_data(sf_sdata), .avalonst_sink_empty(sf_sempty),
        .avalonst_sink_startofpacket(sf_ssop), .avalonst_sink_endofpacket(sf_seop),
        .avalonst_sink_valid(sf_svalid), .avalonst_sink_ready(sf_sready),
        .avalonst_source_data(sf_qdata), .avalonst_source_empty(sf_qempty),
        .avalonst_source_startofpacket(sf_qsop), .avalonst_source_endofpacket(sf_qeop),
        .avalonst_source_valid(sf_qvalid), .avalonst_source_ready(sf_qready),
        .level(sf_level), .almost_full(sf_af), .pkt_count(sf_pkt)
    );

    function automatic logic [127:0] mkdata(input int tag);
        logic [15:0] t;
        t = tag[15:0];
        return {t, 16'hBEEF, ~t, 16'h1234, t ^ 16'h5A5A, 16'h0F0F, t, 16'hCAFE};
    endfunction

    // {valid, sop, eop, empty, data} as the source should present it
    function automatic logic [134:0] exp_beat(input int tag, input logic sop,
                                              input logic eop, input logic [3:0] emp);
        return {1'b1, sop, eop, emp, mkdata(tag)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ct_drive(input logic v, input int tag, input logic sop,
                            input logic eop, input logic [3:0] emp);
        ct_svalid = v; ct_sdata = mkdata(tag); ct_ssop = sop; ct_seop = eop; ct_sempty = emp;
    endtask

    task automatic sf_drive(input logic v, input int tag, input logic sop,
                            input logic eop, input logic [3:0] emp);
        sf_svalid = v; sf_sdata = mkdata(tag); sf_ssop = sop; sf_seop = eop; sf_sempty = emp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({ct_sready, ct_qvalid, ct_af, sf_sready, sf_qvalid} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held_outputs: got %b want 00000", {ct_sready, ct_qvalid, ct_af, sf_sready, sf_qvalid});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ct_level, ct_pkt} !== 8'h00) begin
            failures++;
            $display("FAIL reset_counts: got level=%0d pkt=%0d want 0 0", ct_level, ct_pkt);
        end
        checks++;
        if ({ct_sready, ct_qvalid, sf_sready, sf_qvalid} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_release_handshake: got %b want 1010", {ct_sready, ct_qvalid, sf_sready, sf_qvalid});
        end
    endtask

    task automatic test_cut_through();
        ct_qready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ct_drive(1'b1, 8 + i, i == 0, i == 2, (i == 2) ? 4'd5 : 4'd0);
            tick();
            checks++;
            if ({ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata} !==
                exp_beat(8 + i, i == 0, i == 2, (i == 2) ? 4'd5 : 4'd0)) begin
                failures++;
                $display("FAIL ct_beat%0d: got %h want %h", i,
                         {ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata},
                         exp_beat(8 + i, i == 0, i == 2, (i == 2) ? 4'd5 : 4'd0));
            end
            checks++;
            if ({ct_level, ct_pkt} !== {4'd1, (i == 2) ? 4'd1 : 4'd0}) begin
                failures++;
                $display("FAIL ct_level_pkt%0d: got level=%0d pkt=%0d want 1 %0d", i, ct_level, ct_pkt, (i == 2) ? 1 : 0);
            end
        end
        ct_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        tick();
        checks++;
        if ({ct_level, ct_pkt, ct_qvalid} !== 9'd0) begin
            failures++;
            $display("FAIL ct_idle: got level=%0d pkt=%0d valid=%b want 0 0 0", ct_level, ct_pkt, ct_qvalid);
        end
        ct_qready = 1'b0;
    endtask

    task automatic test_fill();
        ct_qready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ct_drive(1'b1, 16 + i, 1'b1, 1'b1, 4'd0);
            tick();
            checks++;
            if (ct_level !== 4'(i + 1) || ct_af !== ((i + 1) >= 4)) begin
                failures++;
                $display("FAIL fill_level%0d: got level=%0d af=%b want %0d %b", i, ct_level, ct_af, i + 1, (i + 1) >= 4);
            end
        end
        checks++;
        if ({ct_sready, ct_pkt} !== {1'b0, 4'd8}) begin
            failures++;
            $display("FAIL fill_full: got ready=%b pkt=%0d want 0 8", ct_sready, ct_pkt);
        end
        ct_drive(1'b1, 99, 1'b1, 1'b1, 4'd0);
        tick();
        checks++;
        if ({ct_level, ct_pkt} !== {4'd8, 4'd8}) begin
            failures++;
            $display("FAIL fill_overflow: got level=%0d pkt=%0d want 8 8", ct_level, ct_pkt);
        end
        ct_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        ct_qready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata} !== exp_beat(16 + i, 1'b1, 1'b1, 4'd0)) begin
                failures++;
                $display("FAIL drain_beat%0d: got %h want %h", i,
                         {ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata}, exp_beat(16 + i, 1'b1, 1'b1, 4'd0));
            end
            tick();
        end
        ct_qready = 1'b0;
        checks++;
        if ({ct_level, ct_pkt, ct_qvalid, ct_af} !== 10'd0) begin
            failures++;
            $display("FAIL drain_empty: got level=%0d pkt=%0d valid=%b af=%b want 0 0 0 0", ct_level, ct_pkt, ct_qvalid, ct_af);
        end
    endtask

    task automatic test_back_to_back();
        ct_qready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ct_drive(1'b1, 32 + i, 1'b1, 1'b1, 4'd0);
            tick();
        end
        ct_qready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ct_drive(1'b1, 35 + i, 1'b1, 1'b1, 4'd0);
            checks++;
            if ({ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata} !== exp_beat(32 + i, 1'b1, 1'b1, 4'd0)) begin
                failures++;
                $display("FAIL b2b_beat%0d: got %h want %h", i,
                         {ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata}, exp_beat(32 + i, 1'b1, 1'b1, 4'd0));
            end
            checks++;
            if ({ct_level, ct_pkt} !== {4'd3, 4'd3}) begin
                failures++;
                $display("FAIL b2b_level%0d: got level=%0d pkt=%0d want 3 3", i, ct_level, ct_pkt);
            end
            tick();
        end
        ct_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata} !== exp_beat(52 + i, 1'b1, 1'b1, 4'd0)) begin
                failures++;
                $display("FAIL b2b_tail%0d: got %h want %h", i,
                         {ct_qvalid, ct_qsop, ct_qeop, ct_qempty, ct_qdata}, exp_beat(52 + i, 1'b1, 1'b1, 4'd0));
            end
            tick();
        end
        ct_qready = 1'b0;
        checks++;
        if ({ct_level, ct_pkt} !== 8'h00) begin
            failures++;
            $display("FAIL b2b_empty: got level=%0d pkt=%0d want 0 0", ct_level, ct_pkt);
        end
    endtask

    task automatic test_store_fwd();
        sf_qready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sf_drive(1'b1, 64 + i, i == 0, 1'b0, 4'd0);
            tick();
            checks++;
            if ({sf_qvalid, sf_level} !== {1'b0, 4'(i + 1)}) begin
                failures++;
                $display("FAIL sf_hold%0d: got valid=%b level=%0d want 0 %0d", i, sf_qvalid, sf_level, i + 1);
            end
        end
        sf_drive(1'b1, 68, 1'b0, 1'b1, 4'd3);
        tick();
        checks++;
        if ({sf_qvalid, sf_pkt, sf_level} !== {1'b1, 4'd1, 4'd5}) begin
            failures++;
            $display("FAIL sf_release: got valid=%b pkt=%0d level=%0d want 1 1 5", sf_qvalid, sf_pkt, sf_level);
        end
        sf_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({sf_qvalid, sf_qsop, sf_qeop, sf_qempty, sf_qdata} !==
                exp_beat(64 + i, i == 0, i == 4, (i == 4) ? 4'd3 : 4'd0)) begin
                failures++;
                $display("FAIL sf_beat%0d: got %h want %h", i,
                         {sf_qvalid, sf_qsop, sf_qeop, sf_qempty, sf_qdata},
                         exp_beat(64 + i, i == 0, i == 4, (i == 4) ? 4'd3 : 4'd0));
            end
            tick();
        end
        checks++;
        if ({sf_qvalid, sf_pkt, sf_level} !== 9'd0) begin
            failures++;
            $display("FAIL sf_drained: got valid=%b pkt=%0d level=%0d want 0 0 0", sf_qvalid, sf_pkt, sf_level);
        end
    endtask

    task automatic test_oversize();
        int   tx;
        logic acc;
        sf_qready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sf_drive(1'b1, 80 + i, i == 0, 1'b0, 4'd0);
            tick();
        end
        checks++;
        if ({sf_level, sf_qvalid, sf_sready} !== {4'd8, 2'b00}) begin
            failures++;
            $display("FAIL ovs_full: got level=%0d valid=%b ready=%b want 8 0 0", sf_level, sf_qvalid, sf_sready);
        end
        sf_drive(1'b1, 88, 1'b0, 1'b0, 4'd0);
        tick();
        checks++;
        if ({sf_level, sf_qvalid} !== {4'd8, 1'b1}) begin
            failures++;
            $display("FAIL ovs_forced: got level=%0d valid=%b want 8 1", sf_level, sf_qvalid);
        end
        sf_qready = 1'b1;
        tx = 8;
        for (int c = 0; c < 12; c++) begin
            if (tx < 12) sf_drive(1'b1, 80 + tx, 1'b0, tx == 11, 4'd0);
            else         sf_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
            checks++;
            if ({sf_qvalid, sf_qsop, sf_qeop, sf_qempty, sf_qdata} !== exp_beat(80 + c, c == 0, c == 11, 4'd0)) begin
                failures++;
                $display("FAIL ovs_beat%0d: got %h want %h", c,
                         {sf_qvalid, sf_qsop, sf_qeop, sf_qempty, sf_qdata}, exp_beat(80 + c, c == 0, c == 11, 4'd0));
            end
            acc = sf_svalid & sf_sready;
            tick();
            if (acc) tx++;
        end
        sf_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (tx !== 12 || {sf_level, sf_pkt, sf_qvalid} !== 9'd0) begin
            failures++;
            $display("FAIL ovs_done: got tx=%0d level=%0d pkt=%0d valid=%b want 12 0 0 0", tx, sf_level, sf_pkt, sf_qvalid);
        end
        sf_drive(1'b1, 96, 1'b1, 1'b0, 4'd0);
        tick();
        checks++;
        if (sf_qvalid !== 1'b0) begin
            failures++;
            $display("FAIL ovs_next_held: got valid=%b want 0", sf_qvalid);
        end
        sf_drive(1'b1, 97, 1'b0, 1'b1, 4'd2);
        tick();
        checks++;
        if ({sf_qvalid, sf_pkt} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL ovs_next_release: got valid=%b pkt=%0d want 1 1", sf_qvalid, sf_pkt);
        end
        sf_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({sf_qvalid, sf_qsop, sf_qeop, sf_qempty, sf_qdata} !==
                exp_beat(96 + i, i == 0, i == 1, (i == 1) ? 4'd2 : 4'd0)) begin
                failures++;
                $display("FAIL ovs_next_beat%0d: got %h want %h", i,
                         {sf_qvalid, sf_qsop, sf_qeop, sf_qempty, sf_qdata},
                         exp_beat(96 + i, i == 0, i == 1, (i == 1) ? 4'd2 : 4'd0));
            end
            tick();
        end
        checks++;
        if ({sf_level, sf_pkt} !== 8'h00) begin
            failures++;
            $display("FAIL ovs_next_empty: got level=%0d pkt=%0d want 0 0", sf_level, sf_pkt);
        end
    endtask

    task automatic test_reset_mid_packet();
        ct_qready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ct_drive(1'b1, 112 + i, i == 0, 1'b0, 4'd0);
            tick();
        end
        checks++;
        if ({ct_level, ct_af} !== {4'd5, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_pre: got level=%0d af=%b want 5 1", ct_level, ct_af);
        end
        rst = 1'b1;
        ct_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++;
        if ({ct_sready, ct_qvalid, ct_af} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_held: got ready=%b valid=%b af=%b want 0 0 0", ct_sready, ct_qvalid, ct_af);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({ct_level, ct_pkt, ct_qvalid, ct_sready} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_after: got level=%0d pkt=%0d valid=%b ready=%b want 0 0 0 1",
                     ct_level, ct_pkt, ct_qvalid, ct_sready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ct_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        sf_drive(1'b0, 0, 1'b0, 1'b0, 4'd0);
        ct_qready = 1'b0;
        sf_qready = 1'b0;
        test_reset();
        test_cut_through();
        test_fill();
        test_back_to_back();
        test_store_fwd();
        test_oversize();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
